bbpd_bank: RTL



---
 rtl/bbpd_bank.sv | 133 +++++++++++++
 1 files changed

// File: rtl/bbpd_bank.sv
// bbpd_bank: WIDTH-bit bidirectional pad bank with registered drive, a bus-turnaround
// sequencer on the output enables, synchronised inputs and sticky rise/fall flags.
module bbpd_bank #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TURNAROUND  = 1,
  parameter bit PULLDOWN    = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  inout  wire  [WIDTH-1:0] pad_io,
  input  logic [WIDTH-1:0] out_data,
  input  logic [WIDTH-1:0] out_en,
  input  logic [WIDTH-1:0] flag_clr,
  output logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] rise_flags,
  output logic [WIDTH-1:0] fall_flags,
  output logic [WIDTH-1:0] oe_active,
  output logic             dir_busy
);

  typedef enum logic {STABLE, TURN} seq_state_e;

  localparam logic [3:0] TURN_LOAD   = 4'(TURNAROUND);
  localparam logic [2:0] SETTLE_DONE = 3'(SYNC_STAGES + 1);

  seq_state_e                        state_q, state_d;
  logic [3:0]                        cnt_q, cnt_d;
  logic [WIDTH-1:0]                  oe_d, out_q, req_q;
  logic [WIDTH-1:0]                  pending, withdrawn;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  prev_q, edge_en, rise_set, fall_set;
  logic [2:0]                        settle_q;

  // Pad drivers: registered data gated by the applied enable.
  for (genvar i = 0; i < WIDTH; i++) begin : g_pad
    assign pad_io[i] = oe_active[i] ? out_q[i] : 1'bz;
    if (PULLDOWN) begin : g_pd
      pulldown u_pd (pad_io[i]);
    end
  end

  // Bits asking to drive that are not yet driving, and bits whose request was
  // withdrawn since last cycle (the latter restart a running turnaround).
  assign pending   = out_en & ~oe_active;
  assign withdrawn = req_q & ~out_en;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= STABLE;
      cnt_q     <= '0;
      oe_active <= '0;
      out_q     <= '0;
      req_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      oe_active <= oe_d;
      out_q     <= out_data;
      req_q     <= out_en;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    oe_d    = oe_active & out_en;  // releases are never delayed
    unique case (state_q)
      STABLE: begin
        if (pending != '0) begin
          if (TURNAROUND == 0) begin
            oe_d = out_en;
          end else begin
            state_d = TURN;
            cnt_d   = TURN_LOAD;
          end
        end
      end
      TURN: begin
        if (pending == '0) begin
          state_d = STABLE;
        end else if (withdrawn != '0) begin
          cnt_d = TURN_LOAD;
        end else if (cnt_q == 4'd1) begin
          oe_d    = out_en;
          state_d = STABLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = STABLE;
    endcase
  end

  always_comb begin
    dir_busy = (state_q == TURN);
  end

  // NOTE: the synchroniser and edge history are reset so that reset exit
  // presents a known-low input and cannot fabricate edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      prev_q   <= '0;
      settle_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad_io};
      prev_q <= in_data;
      if (settle_q != SETTLE_DONE) settle_q <= settle_q + 3'd1;
    end
  end

  assign in_data = sync_q[SYNC_STAGES-1];

  // Driven pins and the post-reset settle window never raise flags.
  assign edge_en  = (settle_q == SETTLE_DONE) ? ~oe_active : '0;
  assign rise_set = ~prev_q & in_data & edge_en;
  assign fall_set = prev_q & ~in_data & edge_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_flags <= '0;
      fall_flags <= '0;
    end else begin
      rise_flags <= (rise_flags & ~flag_clr) | rise_set;
      fall_flags <= (fall_flags & ~flag_clr) | fall_set;
    end
  end

endmodule
